ram32x8: RTL and testbench

- Small single-port random-access data memory for the 8-bit processor datapath.
- Default size is 32 words of 8 bits.
- Writes are synchronous to the system clock; reads are combinational (asynchronous).
- Sits between the address/data buses and the register file; used for load/store operands.

---
 rtl/ram32x8_pkg.sv | 12 +
 rtl/ram32x8.sv | 41 ++++
 tb/tb_ram32x8.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ram32x8_pkg.sv
// ram32x8 shared constants and types.
// Data memory geometry for the 8-bit datapath.
package ram32x8_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

  typedef logic [RAM_ADDR_W-1:0] addr_t;
  typedef logic [RAM_DATA_W-1:0] data_t;

endpackage

// File: rtl/ram32x8.sv
// ram32x8: resettable flip-flop data memory.
// Synchronous write, combinational read, async clear.
module ram32x8
  import ram32x8_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear the whole array on reset; otherwise write one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= data_in;
    end
  end

  // Reset holds every word at zero, so no extra gating is needed.
  assign data_out = mem[addr];

  // Control inputs must be known whenever a write could occur.
  a_ctrl_known: assert property (
    @(posedge clk) disable iff (!rst_n)
    !$isunknown({we, addr})
  );

endmodule

// File: tb/tb_ram32x8.sv
// tb_ram32x8: self-checking bench for ram32x8.
// Array model plus directed literal checks.
module tb_ram32x8;
  import ram32x8_pkg::*;

  logic  clk;
  logic  rst_n;
  addr_t addr;
  data_t data_in;
  logic  we;
  data_t data_out;

  int checks;
  int failures;
  bit chk_en;

  data_t model [RAM_DEPTH];

  ram32x8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: reset zeroes everything, a write edge stores one word.
  always @(posedge clk or negedge rst_n) begin
    if (rst_n !== 1'b1) begin
      for (int i = 0; i < RAM_DEPTH; i++) model[i] = '0;
    end else if (we === 1'b1) begin
      model[addr] = data_in;
    end
  end

  // Compare read data against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (data_out !== model[addr]) begin
        failures++;
        $display("FAIL model_cmp addr=%0d got=%h exp=%h",
                 addr, data_out, model[addr]);
      end
    end
  end

  task automatic check(input string name, input data_t exp);
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("FAIL %s addr=%0d got=%h exp=%h",
               name, addr, data_out, exp);
    end
  endtask

  task automatic wr(input addr_t a, input data_t d);
    addr    = a;
    data_in = d;
    we      = 1'b1;
    @(posedge clk);
    #1;
    we      = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b1;
    addr     = '0;
    data_in  = '0;
    we       = 1'b0;

    #1 rst_n = 1'b0;
    #2 check("rst_hold_a0", 8'h00);
    addr = 5'd31;
    #1 check("rst_hold_a31", 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    addr = 5'd0;
    #2 check("post_rst_a0", 8'h00);
    addr = 5'd31;
    #2 check("post_rst_a31", 8'h00);

    wr(5'd1, 8'hAA);
    addr = 5'd0;
    #1 check("first_wr_a0", 8'h00);
    addr = 5'd1;
    #1 check("first_wr_a1", 8'hAA);

    for (int i = 0; i < RAM_DEPTH; i++) begin
      wr(addr_t'(i), data_t'(i) ^ 8'h5A);
    end
    for (int i = 0; i < RAM_DEPTH; i++) begin
      addr = addr_t'(i);
      #1 check("pattern", data_t'(i) ^ 8'h5A);
    end
    addr = 5'd0;
    #1 check("pattern_a0", 8'h5A);
    addr = 5'd31;
    #1 check("pattern_a31", 8'h45);

    wr(5'd1, 8'hAA);
    data_in = 8'h55;
    we      = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("no_we_hold", 8'hAA);

    addr    = 5'd1;
    data_in = 8'h3C;
    we      = 1'b1;
    #1 check("rdw_before", 8'hAA);
    @(posedge clk);
    #1 we = 1'b0;
    check("rdw_after", 8'h3C);
    addr = 5'd0;
    #1 check("nbr_a0", 8'h5A);
    addr = 5'd2;
    #1 check("nbr_a2", 8'h58);

    for (int i = 0; i < RAM_DEPTH; i++) begin
      wr(addr_t'(i), data_t'(i + 1));
    end
    addr = 5'd6;
    #1 check("fill_a6", 8'h07);

    addr    = 5'd7;
    data_in = 8'hFF;
    we      = 1'b1;
    @(posedge clk);
    #2 check("wr_before_rst", 8'hFF);
    rst_n = 1'b0;
    #1 check("rst_async", 8'h00);
    addr = 5'd20;
    #1 check("rst_async_a20", 8'h00);
    @(posedge clk);
    #1 check("rst_ignores_we", 8'h00);
    we = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      addr = addr_t'(i);
      #1 check("post_rst_all", 8'h00);
    end

    wr(5'd9, 8'hC3);
    addr = 5'd9;
    #1 check("wr_after_rst", 8'hC3);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
